// File: rtl/morse_player_pkg.sv
// Shared Morse definitions: symbol encodings, FSM states and default tick counts.
// Imported by the morse_player top and its symbol timer.
package morse_player_pkg;

  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_RSVD  = 2'b10;
  localparam logic [1:0] SYM_DASH  = 2'b11;

  localparam int DEF_DOT_TICKS  = 1;
  localparam int DEF_DASH_TICKS = 3;
  localparam int DEF_SYM_GAP    = 1;
  localparam int DEF_LETTER_GAP = 3;
  localparam int DEF_WORD_GAP   = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ON,
    S_GAP,
    S_LGAP,
    S_WGAP,
    S_DONE
  } state_t;

  // Reserved code 10 is treated like an empty slot.
  function automatic logic sym_is_tone(input logic [1:0] sym);
    return (sym == SYM_DOT) || (sym == SYM_DASH);
  endfunction

  function automatic int max_ticks(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/morse_player_sym_timer.sv
// Tick counter for one Morse element: load a duration, count down, flag the last tick.
module morse_player_sym_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock_1hz,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // The element ends on the tick where the count reads one.
  assign expire = (count <= WIDTH'(1));

endmodule

// File: rtl/morse_player.sv
// Morse transmitter: replays stored letters from RAM as timed tone pulses.
// Optional MORSE_REPEAT_EN: loop forever with a word gap instead of stopping in DONE.
module morse_player
  import morse_player_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 10,
  parameter int DOT_TICKS  = DEF_DOT_TICKS,
  parameter int DASH_TICKS = DEF_DASH_TICKS,
  parameter int SYM_GAP    = DEF_SYM_GAP,
  parameter int LETTER_GAP = DEF_LETTER_GAP,
  parameter int WORD_GAP   = DEF_WORD_GAP
) (
  input  logic              clock_1hz,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              tone,
  output logic [1:0]        cur_sym,
  output logic              busy,
  output logic              done
);

  localparam int TMR_W = $clog2(max_ticks(DOT_TICKS, DASH_TICKS, SYM_GAP,
                                          LETTER_GAP, WORD_GAP) + 1);

  state_t            state, next_state;
  logic [DATA_W-1:0] shreg;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_expire;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_word;
  logic [1:0]        head_sym;
  logic [1:0]        next_sym;

  function automatic logic [TMR_W-1:0] sym_ticks(input logic [1:0] sym);
    return (sym == SYM_DASH) ? TMR_W'(DASH_TICKS) : TMR_W'(DOT_TICKS);
  endfunction

  assign head_sym  = shreg[DATA_W-1 -: 2];
  assign next_sym  = shreg[DATA_W-3 -: 2];
  assign addr_inc  = ram_addr + ADDR_W'(1);
  assign last_word = (addr_inc == num_words);

  morse_player_sym_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clock_1hz(clock_1hz),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every entry into a timed state loads the timer with that state's duration.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          next_state = (num_words == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        next_state = S_LOAD;
      end
      S_LOAD: begin
        if (sym_is_tone(ram_q[DATA_W-1 -: 2])) begin
          next_state = S_ON;
          tmr_load   = 1'b1;
          tmr_val    = sym_ticks(ram_q[DATA_W-1 -: 2]);
        end else begin
          next_state = S_DONE;
        end
      end
      S_ON: begin
        // Zeros shift in behind the symbols, so after the fifth one the next slot is empty.
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (sym_is_tone(next_sym)) begin
            next_state = S_GAP;
            tmr_val    = TMR_W'(SYM_GAP);
          end else begin
            next_state = S_LGAP;
            tmr_val    = TMR_W'(LETTER_GAP);
          end
        end
      end
      S_GAP: begin
        if (tmr_expire) begin
          next_state = S_ON;
          tmr_load   = 1'b1;
          tmr_val    = sym_ticks(head_sym);
        end
      end
      S_LGAP: begin
        if (tmr_expire) begin
          if (last_word) begin
`ifdef MORSE_REPEAT_EN
            next_state = S_WGAP;
            tmr_load   = 1'b1;
            tmr_val    = TMR_W'(WORD_GAP);
`else
            next_state = S_DONE;
`endif
          end else begin
            next_state = S_FETCH;
          end
        end
      end
      S_WGAP: begin
        if (tmr_expire) begin
          next_state = S_FETCH;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Address counter and symbol shift register follow the FSM's decisions.
  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      ram_addr <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) ram_addr <= '0;
        S_LOAD:         shreg <= ram_q;
        S_ON:           if (tmr_expire) shreg <= {shreg[DATA_W-3:0], 2'b00};
        S_LGAP:         if (tmr_expire) ram_addr <= addr_inc;
        S_WGAP:         if (tmr_expire) ram_addr <= '0;
        default: ;
      endcase
    end
  end

  assign tone    = (state == S_ON);
  assign cur_sym = tone ? head_sym : SYM_EMPTY;
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);

endmodule
